// File: rtl/ipg_rx_stream.sv
// IPG side-channel receiver: strips payload bytes out of IPG-carrying control
// blocks into a byte FIFO, hands an ordinary idle block to the decoder, and
// streams the payload out as keep/last-framed words of OUT_BYTES bytes.
// Legal configuration: DATA_WIDTH=64, HDR_WIDTH=2, FIFO_DEPTH a power of two
// >= 16, OUT_BYTES in {1,2,4,8}.
module ipg_rx_stream #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         HDR_WIDTH      = 2,
    parameter logic [7:0] IPG_BLOCK_TYPE = 8'h1E,
    parameter int         FIFO_DEPTH     = 64,
    parameter int         OUT_BYTES      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]   encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0]  recovered_rx_data,
    output logic [HDR_WIDTH-1:0]   recovered_rx_hdr,
    output logic [8*OUT_BYTES-1:0] m_tdata,
    output logic [OUT_BYTES-1:0]   m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   ipg_overflow,
    output logic                   ipg_bad_len,
    output logic [15:0]            drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;              // occupancy needs one extra bit for "full"
    localparam int NW = $clog2(OUT_BYTES) + 1;

    localparam logic [DATA_WIDTH-1:0] IDLE_BLK = DATA_WIDTH'(IPG_BLOCK_TYPE);

    // FIFO entry: {last, byte}
    logic [8:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;

    logic [DATA_WIDTH-1:0] r_rec_data;
    logic [HDR_WIDTH-1:0]  r_rec_hdr;
    logic                  r_s_ipg, r_s_eom;
    logic [5:0]            r_s_len;
    logic [47:0]           r_s_pay;
    logic                  r_ovf, r_bad;
    logic [15:0]           r_drop;

    logic                  w_is_ipg;
    logic [CW-1:0]         w_free;
    logic                  w_bad, w_ovf, w_wr;
    logic [2:0]            w_wr_n;
    logic [AW-1:0]         w_widx [6];
    logic [AW-1:0]         w_ridx [OUT_BYTES];
    logic [8:0]            w_ent  [OUT_BYTES];
    logic [OUT_BYTES-1:0]  w_in;
    logic [NW-1:0]         w_n, w_pop_n;
    logic                  w_hit, w_valid;

    assign w_is_ipg = (encoded_rx_hdr == 2'b10) && (encoded_rx_data[7:0] == IPG_BLOCK_TYPE);

    // Recovered path and capture of the IPG fields for next cycle's FIFO write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_hdr  <= 2'b10;
            r_rec_data <= IDLE_BLK;
            r_s_ipg    <= 1'b0;
            r_s_eom    <= 1'b0;
            r_s_len    <= '0;
            r_s_pay    <= '0;
        end else begin
            r_rec_hdr  <= encoded_rx_hdr;
            r_rec_data <= w_is_ipg ? IDLE_BLK : encoded_rx_data;
            r_s_ipg    <= w_is_ipg;
            r_s_eom    <= encoded_rx_data[14];
            r_s_len    <= encoded_rx_data[13:8];
            r_s_pay    <= encoded_rx_data[63:16];
        end
    end

    // Accept/reject decision; free space ignores this cycle's pop on purpose
    always_comb begin
        w_free = CW'(FIFO_DEPTH) - r_count;
        w_bad  = r_s_ipg && (r_s_len > 6'd6);
        w_ovf  = r_s_ipg && !w_bad && (32'(r_s_len) > 32'(w_free));
        w_wr   = r_s_ipg && !w_bad && !w_ovf && (r_s_len != 6'd0);
        w_wr_n = w_wr ? r_s_len[2:0] : 3'd0;
    end

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_widx
            assign w_widx[g] = r_wptr + AW'(g);
        end
        for (g = 0; g < OUT_BYTES; g++) begin : g_win
            assign w_ridx[g] = r_rptr + AW'(g);
            assign w_ent[g]  = r_mem[w_ridx[g]];
            assign w_in[g]   = CW'(g) < r_count;
            assign m_tdata[8*g +: 8] = (w_valid && (NW'(g) < w_n)) ? w_ent[g][7:0] : 8'h00;
            assign m_tkeep[g]        = w_valid && (NW'(g) < w_n);
        end
    endgenerate

    // Payload bytes land contiguously (mod depth); last flag only on the final byte of an eom block
    always_ff @(posedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (w_wr && (6'(k) < r_s_len))
                r_mem[w_widx[k]] <= {r_s_eom && (6'(k + 1) == r_s_len), r_s_pay[8*k +: 8]};
        end
    end

    // Word length: up to the first last-flagged byte in the head window, else a full word
    always_comb begin
        w_n   = NW'(OUT_BYTES);
        w_hit = 1'b0;
        for (int i = OUT_BYTES - 1; i >= 0; i--) begin
            if (w_in[i] && w_ent[i][8]) begin
                w_n   = NW'(i + 1);
                w_hit = 1'b1;
            end
        end
    end

    assign w_valid  = w_hit || (r_count >= CW'(OUT_BYTES));
    assign w_pop_n  = (w_valid && m_tready) ? w_n : '0;
    assign m_tvalid = w_valid;
    assign m_tlast  = w_valid && w_hit;

    // FIFO pointers, occupancy, status pulses and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_bad   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_wr_n);
            r_rptr  <= r_rptr + AW'(w_pop_n);
            r_count <= r_count + CW'(w_wr_n) - CW'(w_pop_n);
            r_ovf   <= w_ovf;
            r_bad   <= w_bad;
            if ((w_ovf || w_bad) && (r_drop != 16'hFFFF))
                r_drop <= r_drop + 16'd1;
        end
    end

    assign recovered_rx_data = r_rec_data;
    assign recovered_rx_hdr  = r_rec_hdr;
    assign ipg_overflow      = r_ovf;
    assign ipg_bad_len       = r_bad;
    assign drop_count        = r_drop;

endmodule

// File: tb/tb_ipg_rx_stream.sv
// Bench for ipg_rx_stream: directed scenarios pinned with literal values, then
// random traffic, all compared every cycle against a queue-based byte model.
module tb_ipg_rx_stream;
    localparam int FD = 16;
    localparam int OB = 4;

    logic          clk;
    logic          rst_n;
    logic [63:0]   enc_data;
    logic [1:0]    enc_hdr;
    logic [63:0]   rec_data;
    logic [1:0]    rec_hdr;
    logic [8*OB-1:0] m_tdata;
    logic [OB-1:0] m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;
    logic          ipg_overflow, ipg_bad_len;
    logic [15:0]   drop_count;

    int n_chk = 0;
    int n_fail = 0;
    int ovf_seen = 0;

    ipg_rx_stream #(.FIFO_DEPTH(FD), .OUT_BYTES(OB)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .encoded_rx_data(enc_data), .encoded_rx_hdr(enc_hdr),
        .recovered_rx_data(rec_data), .recovered_rx_hdr(rec_hdr),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .ipg_overflow(ipg_overflow), .ipg_bad_len(ipg_bad_len),
        .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_ipg(input int len, input bit eom, input logic [47:0] pay);
        return {pay, 1'b0, eom, 6'(len), 8'h1E};
    endfunction

    // ---------------- behavioural model ----------------
    logic [8:0]  q[$];          // {last, byte} in arrival order
    bit          pend_ipg;
    logic [63:0] pend_data;
    logic [63:0] e_rec_data;
    logic [1:0]  e_rec_hdr;
    bit          e_ovf, e_bad;
    int          e_drop;

    // Head window: word length n, whether a last flag was found, and validity
    function automatic void window(output int n, output bit hit, output bit v);
        int lim;
        lim = (q.size() < OB) ? q.size() : OB;
        n = OB;
        hit = 0;
        for (int i = 0; i < lim; i++) begin
            if (q[i][8]) begin
                n = i + 1;
                hit = 1;
                break;
            end
        end
        v = hit || (q.size() >= OB);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            pend_ipg = 0; pend_data = '0;
            e_rec_hdr = 2'b10; e_rec_data = 64'h1E;
            e_ovf = 0; e_bad = 0; e_drop = 0;
        end else begin
            int free, len, n;
            bit hit, v;
            free = FD - q.size();
            window(n, hit, v);
            e_ovf = 0; e_bad = 0;
            if (v && m_tready) repeat (n) void'(q.pop_front());
            if (pend_ipg) begin
                len = int'(pend_data[13:8]);
                if (len > 6) begin
                    e_bad = 1;
                    if (e_drop < 65535) e_drop++;
                end else if (len > free) begin
                    e_ovf = 1;
                    if (e_drop < 65535) e_drop++;
                end else begin
                    for (int k = 0; k < len; k++)
                        q.push_back({(pend_data[14] && k == len - 1), pend_data[16+8*k +: 8]});
                end
            end
            pend_ipg  = (enc_hdr == 2'b10) && (enc_data[7:0] == 8'h1E);
            pend_data = enc_data;
            e_rec_hdr  = enc_hdr;
            e_rec_data = pend_ipg ? 64'h1E : enc_data;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int n;
        bit hit, v;
        logic [8*OB-1:0] ed;
        logic [OB-1:0] ek;
        window(n, hit, v);
        ed = '0; ek = '0;
        for (int i = 0; i < n && i < q.size(); i++) begin
            ed[8*i +: 8] = q[i][7:0];
            ek[i] = 1'b1;
        end
        if (ipg_overflow === 1'b1) ovf_seen++;
        chk("rec_hdr", 64'(rec_hdr), 64'(e_rec_hdr));
        chk("rec_data", rec_data, e_rec_data);
        chk("tvalid", 64'(m_tvalid), 64'(v));
        if (v) begin
            chk("tdata", 64'(m_tdata), 64'(ed));
            chk("tkeep", 64'(m_tkeep), 64'(ek));
            chk("tlast", 64'(m_tlast), 64'(hit));
        end
        chk("overflow", 64'(ipg_overflow), 64'(e_ovf));
        chk("bad_len", 64'(ipg_bad_len), 64'(e_bad));
        chk("drop_count", 64'(drop_count), 64'(e_drop));
    end

    task automatic cyc(input logic [1:0] h, input logic [63:0] d, input logic rdy);
        enc_hdr = h; enc_data = d; m_tready = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ovf0, r, len;
        logic [63:0] rd;
        rst_n = 1'b0; enc_hdr = 2'b10; enc_data = 64'h1E; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rec_hdr", 64'(rec_hdr), 64'h2);
        chk("rst_rec_data", rec_data, 64'h1E);
        chk("rst_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_tdata", 64'(m_tdata), 64'h0);
        chk("rst_drop", 64'(drop_count), 64'h0);
        rst_n = 1'b1;

        // idle then a data block: straight pass-through
        cyc(2'b10, 64'h1E, 1'b0);
        chk("idle_pass", rec_data, 64'h1E);
        cyc(2'b01, 64'hDEADBEEF_01234567, 1'b0);
        chk("data_pass", rec_data, 64'hDEADBEEF_01234567);
        chk("data_hdr", 64'(rec_hdr), 64'h1);
        chk("data_novalid", 64'(m_tvalid), 64'h0);

        // 6-byte block then 3-byte eom block
        cyc(2'b10, mk_ipg(6, 0, 48'h060504030201), 1'b0);
        chk("ipg_rec_idle", rec_data, 64'h1E);
        cyc(2'b10, 64'h1E, 1'b0);
        chk("w1_tdata", 64'(m_tdata), 64'h04030201);
        chk("w1_tkeep", 64'(m_tkeep), 64'hF);
        chk("w1_tlast", 64'(m_tlast), 64'h0);
        cyc(2'b10, mk_ipg(3, 1, 48'h090807), 1'b1);
        repeat (4) cyc(2'b10, 64'h1E, 1'b1);
        chk("msg_drained", 64'(m_tvalid), 64'h0);

        // overflow: 11 six-byte blocks into a 16-byte FIFO with no reads
        rst_n = 1'b0;
        cyc(2'b10, 64'h1E, 1'b0);
        rst_n = 1'b1;
        ovf0 = ovf_seen;
        cyc(2'b10, mk_ipg(6, 0, 48'h665544332211), 1'b0);
        repeat (10) cyc(2'b10, mk_ipg(6, 0, {16'h0, $urandom}), 1'b0);
        repeat (2) cyc(2'b10, 64'h1E, 1'b0);
        chk("ovf_drop", 64'(drop_count), 64'd9);
        chk("ovf_pulses", 64'(ovf_seen - ovf0), 64'd9);
        chk("ovf_head", 64'(m_tdata), 64'h44332211);

        // bad length
        cyc(2'b10, mk_ipg(7, 1, 48'hFFFFFFFFFFFF), 1'b0);
        chk("bad_rec_idle", rec_data, 64'h1E);
        cyc(2'b10, 64'h1E, 1'b0);
        chk("bad_pulse", 64'(ipg_bad_len), 64'h1);
        chk("bad_drop", 64'(drop_count), 64'd10);
        cyc(2'b10, 64'h1E, 1'b0);
        chk("bad_pulse_end", 64'(ipg_bad_len), 64'h0);

        // reset with a full-ish FIFO and a valid word presented
        chk("pre_rst_valid", 64'(m_tvalid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_tvalid), 64'h0);
        chk("mid_rst_drop", 64'(drop_count), 64'h0);
        chk("mid_rst_tdata", 64'(m_tdata), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(2'b10, 64'h1E, 1'b1);
        chk("post_rst_valid", 64'(m_tvalid), 64'h0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            r = $urandom_range(0, 9);
            rd = {$urandom, $urandom};
            if (r <= 5) begin
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 63) : $urandom_range(0, 6);
                cyc(2'b10, mk_ipg(len, 1'($urandom_range(0, 1)), rd[47:0]), 1'($urandom_range(0, 9) < 6));
            end else if (r == 6) begin
                cyc(2'b10, 64'h1E, 1'($urandom_range(0, 9) < 6));
            end else if (r == 7) begin
                cyc(2'b10, rd, 1'($urandom_range(0, 9) < 6));
            end else begin
                cyc(2'($urandom_range(0, 3)), rd, 1'($urandom_range(0, 9) < 6));
            end
        end
        repeat (20) cyc(2'b10, 64'h1E, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
